// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready and shifts it
// out one bit per BIT_CYCLES clocks with frame-start/frame-end strobes.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bitcnt;
  logic [HW-1:0]    r_hold;

  logic w_shifting;
  logic w_last_bit;
  logic w_last_hold;
  logic w_frame_end;
  logic w_xfer;
  logic w_head;

  assign w_shifting  = (r_state == S_SHIFT);
  assign w_last_bit  = (r_bitcnt == BW'(WIDTH - 1));
  assign w_last_hold = (r_hold == HW'(BIT_CYCLES - 1));
  assign w_frame_end = w_shifting && w_last_bit && w_last_hold;
  assign w_xfer      = din_valid && din_ready;
  assign w_head      = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];

  // Ready in the final hold cycle lets the next word reload with no idle gap.
  assign din_ready  = !w_shifting || w_frame_end;
  assign sout_valid = w_shifting;
  assign busy       = w_shifting;
  assign sout       = w_shifting && w_head;
  assign sof        = w_shifting && (r_bitcnt == '0);
  assign eof        = w_shifting && w_last_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_frame_end && !w_xfer) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_hold   <= '0;
    end else if (w_xfer) begin
      r_shift  <= din;
      r_bitcnt <= '0;
      r_hold   <= '0;
    end else if (w_shifting) begin
      if (w_last_hold) begin
        r_hold <= '0;
        if (w_last_bit) begin
          r_bitcnt <= '0;
          r_shift  <= '0;
        end else begin
          r_bitcnt <= r_bitcnt + BW'(1);
          r_shift  <= (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
        end
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Checks two serializer configurations against a queue model of the expected
// per-cycle serial stream.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din_a, din_b;
  logic       v_a, v_b;
  logic       rdy_a, sout_a, sv_a, sof_a, eof_a, busy_a;
  logic       rdy_b, sout_b, sv_b, sof_b, eof_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry is one clock of expected output: {sof, eof, bit}.
  typedef logic [2:0] ent_t;
  typedef ent_t       ent_q_t[$];
  ent_q_t q_a, q_b;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .BIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(v_a), .din_ready(rdy_a),
    .sout(sout_a), .sout_valid(sv_a), .sof(sof_a), .eof(eof_a), .busy(busy_a)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .BIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(v_b), .din_ready(rdy_b),
    .sout(sout_b), .sout_valid(sv_b), .sof(sof_b), .eof(eof_b), .busy(busy_b)
  );

  function automatic ent_q_t frame(logic [3:0] w, int msb, int bc);
    ent_q_t f;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (msb != 0) ? 3 - i : i;
      for (int c = 0; c < bc; c++) f.push_back({(i == 0), (i == 3), w[idx]});
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t ea, eb;
    ea = (q_a.size() != 0) ? q_a[0] : 3'b000;
    eb = (q_b.size() != 0) ? q_b[0] : 3'b000;
    chk("a_valid", sv_a, (q_a.size() != 0));
    chk("a_busy", busy_a, (q_a.size() != 0));
    chk("a_sout", sout_a, ea[0]);
    chk("a_sof", sof_a, ea[2]);
    chk("a_eof", eof_a, ea[1]);
    chk("a_ready", rdy_a, (q_a.size() <= 1));
    chk("b_valid", sv_b, (q_b.size() != 0));
    chk("b_busy", busy_b, (q_b.size() != 0));
    chk("b_sout", sout_b, eb[0]);
    chk("b_sof", sof_b, eb[2]);
    chk("b_eof", eof_b, eb[1]);
    chk("b_ready", rdy_b, (q_b.size() <= 1));
  endtask

  task automatic model_edge();
    logic ra, rb;
    if (!rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      ra = (q_a.size() <= 1);
      rb = (q_b.size() <= 1);
      if (q_a.size() != 0) void'(q_a.pop_front());
      if (q_b.size() != 0) void'(q_b.pop_front());
      if (v_a && ra) q_a = {q_a, frame(din_a, 1, 1)};
      if (v_b && rb) q_b = {q_b, frame(din_b, 0, 3)};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_now();
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b0; din_a = '0; din_b = '0; v_a = 1'b0; v_b = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Single frame 1101 on both instances, din scrambled after the transfer.
    din_a = 4'b1101; v_a = 1'b1; din_b = 4'b1101; v_b = 1'b1;
    tick();
    v_a = 1'b0; v_b = 1'b0;
    for (int i = 0; i < 14; i++) begin
      din_a = 4'($urandom);
      din_b = 4'($urandom);
      tick();
    end

    // Back-to-back 1101 then 1000 with valid held high.
    din_a = 4'b1101; v_a = 1'b1;
    tick();
    din_a = 4'b1000;
    repeat (4) tick();
    v_a = 1'b0;
    repeat (2) tick();

    // Reset mid-frame, then confirm no resumption and a clean new frame.
    reset_now();
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    din_a = 4'b0110; v_a = 1'b1; din_b = 4'b0110; v_b = 1'b1;
    tick();
    v_a = 1'b0; v_b = 1'b0;
    repeat (14) tick();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      din_a = 4'($urandom);
      din_b = 4'($urandom);
      v_a   = ($urandom_range(0, 3) != 0);
      v_b   = ($urandom_range(0, 3) != 0);
      if (rst && ($urandom_range(0, 79) == 0)) begin
        reset_now();
      end else if (!rst && ($urandom_range(0, 1) == 0)) begin
        rst = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
